lcd_timing_pattern_gen: RTL and testbench
=========================================

// Module: lcd_timing_pattern_gen
// PURPOSE
//  Parametrised RGB565 parallel-LCD timing generator with built-in test-pattern source.
//  Produces HSYNC/VSYNC/DE, pixel coordinates, a frame-start strobe, and one of four patterns.
//  Patterns: colour bars, grey gradient, checkerboard, solid colour.
//  Drives the panel pins directly; later designs use PIX_X/PIX_Y/FRAME_START to feed a framebuffer.
// PARAMETERS
//  H_ACTIVE  800  visible pixels per line (>=8)
//  H_FP      210  horizontal front porch, in pixels
//  H_SYNC    1    HSYNC pulse width (>=1)
//  H_BP      45   horizontal back porch
//  V_ACTIVE  480  visible lines per frame
//  V_FP      22   vertical front porch, in lines
//  V_SYNC    1    VSYNC pulse width in lines (>=1)
//  V_BP      22   vertical back porch
//  HS_POL    0    HSYNC active level (0 = active-low)
//  VS_POL    0    VSYNC active level
//  CNT_W     12   width of counters and coordinates; must hold H_TOTAL-1 and V_TOTAL-1
//  CHK_LOG2  5    checkerboard cell size = 2**CHK_LOG2 pixels
// PORTS
//  PixelClk     in   1      pixel clock; all logic on its rising edge
//  RST          in   1      asynchronous reset, active-high
//  MODE         in   2      pattern: 0 bars, 1 gradient, 2 checker, 3 solid
//  SOLID        in   16     RGB565 colour {R5,G6,B5} used in mode 3
//  LCD_DE       out  1      data enable, registered
//  LCD_HSYNC    out  1      horizontal sync, registered
//  LCD_VSYNC    out  1      vertical sync, registered
//  LCD_R        out  5      red
//  LCD_G        out  6      green
//  LCD_B        out  5      blue
//  PIX_X        out  CNT_W  active-area column (0..H_ACTIVE-1); 0 outside active area
//  PIX_Y        out  CNT_W  active-area row (0..V_ACTIVE-1); 0 outside active area
//  FRAME_START  out  1      one-cycle pulse marking h=0,v=0
// BEHAVIOUR
//  - Line and frame lengths: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL likewise.
//  - h_cnt counts 0..H_TOTAL-1 and wraps to 0.
//  - v_cnt increments only when h_cnt wraps; v_cnt counts 0..V_TOTAL-1 and wraps to 0.
//  - Sync and active regions (h shown; v identical with V_* params):
//      sync   while h_cnt < H_SYNC
//      active while H_SYNC+H_BP <= h_cnt < H_SYNC+H_BP+H_ACTIVE
//  - Every output is registered: outputs at cycle n+1 reflect counter state at cycle n.
//  - LCD_DE = h_active & v_active. No combinational path from PixelClk to LCD_DE.
//  - LCD_HSYNC = HS_POL when in h-sync, else ~HS_POL. LCD_VSYNC likewise, per line.
//  - PIX_X = h_cnt-(H_SYNC+H_BP) and PIX_Y = v_cnt-(V_SYNC+V_BP) when DE is active, else 0.
//  - RGB is 0 whenever DE is 0.
//  - FRAME_START = 1 for exactly one cycle per frame, aligned with the first HSYNC of VSYNC.
//  - MODE and SOLID are sampled into shadow registers only at h_cnt=0,v_cnt=0.
//    A mid-frame change takes effect from the next frame; no tearing.
//  - Mode 0, colour bars:
//      BAR_W = H_ACTIVE/8; bar index = min(PIX_X/BAR_W, 7); the last bar absorbs the remainder.
//      Order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
//      Implement with a step counter, not a divider.
//  - Mode 1, grey gradient:
//      STEP = max(H_ACTIVE/64, 1); g = min(PIX_X/STEP, 63).
//      R = g[5:1], G = g, B = g[5:1]. Step counter resets at the start of each active line.
//  - Mode 2, checkerboard: PIX_X[CHK_LOG2] ^ PIX_Y[CHK_LOG2]; 1 = FFFF, 0 = 0000.
//  - Mode 3, solid: the shadowed SOLID value.
//  - Reset:
//      counters, coordinates, DE, RGB and FRAME_START go to 0;
//      HSYNC/VSYNC go to their inactive levels; shadow MODE = 0.
//      Reset asserted mid-line aborts immediately.
//      After release, the first FRAME_START appears one cycle later.
// TESTING (default parameters: H_TOTAL=1056, V_TOTAL=525)
//  1. Release RST -> FRAME_START at cycle 1; LCD_HSYNC low for 1 cycle every 1056;
//     LCD_VSYNC low for 1056 cycles every 554400.
//  2. Count DE-high cycles per line and per frame -> 800 per line, 480 lines,
//     first DE at h_cnt=46 registered; PIX_X runs 0..799.
//  3. MODE=0 -> RGB565 = FFFF at PIX_X=0, FFE0 at 100, 07FF at 299, 0000 at 799;
//     RGB = 0 at DE low.
//  4. MODE=1 -> G = 0 at x=0, 1 at x=12, 63 at x=799 (saturated); R = G>>1.
//     MODE=2 -> colour toggles at x=32 and at y=32.
//  5. Switch MODE 0->3 (SOLID=F800) at mid-frame -> current frame stays bars;
//     next frame is all F800.
//  6. Assert RST for 3 cycles mid-active-line -> DE=0, RGB=0, syncs inactive immediately;
//     clean frame restarts from h=v=0.

Source files
------------

// File: rtl/lcd_timing_pattern_gen_if.sv
// rtl/lcd_timing_pattern_gen_if.sv - panel-side bundle of the LCD timing/pattern generator
//
// Purpose: groups the pattern-select inputs and the registered panel outputs.
// Signals:
//   mode        2      pattern select: 0 bars, 1 gradient, 2 checker, 3 solid
//   solid       16     RGB565 colour {R5,G6,B5} used in mode 3
//   de          1      data enable
//   hsync       1      horizontal sync
//   vsync       1      vertical sync
//   r/g/b       5/6/5  pixel colour
//   pix_x       CNT_W  active-area column, 0 outside the active area
//   pix_y       CNT_W  active-area row, 0 outside the active area
//   frame_start 1      one-cycle pulse for h=0, v=0
// Modports: master = generator side, slave = pattern-select source / panel side.
interface lcd_timing_pattern_gen_if #(
  parameter int CNT_W = 12
);
  logic [1:0]       mode;
  logic [15:0]      solid;
  logic             de;
  logic             hsync;
  logic             vsync;
  logic [4:0]       r;
  logic [5:0]       g;
  logic [4:0]       b;
  logic [CNT_W-1:0] pix_x;
  logic [CNT_W-1:0] pix_y;
  logic             frame_start;

  modport master (
    input  mode, solid,
    output de, hsync, vsync, r, g, b, pix_x, pix_y, frame_start
  );

  modport slave (
    output mode, solid,
    input  de, hsync, vsync, r, g, b, pix_x, pix_y, frame_start
  );
endinterface

// File: rtl/lcd_timing_pattern_gen.sv
// rtl/lcd_timing_pattern_gen.sv - RGB565 parallel-LCD timing generator with test patterns
//
// Purpose: free-running h/v counters produce HSYNC/VSYNC/DE, pixel coordinates and a
// frame-start strobe; an internal source paints colour bars, a grey gradient, a
// checkerboard or a solid colour. Every output is registered from the counter state
// of the previous cycle.
// Ports:
//   pixel_clk_i  in   pixel clock, all logic on its rising edge
//   rst_i        in   asynchronous reset, active-high
//   lcd_if       master modport of lcd_timing_pattern_gen_if (mode/solid in, panel out)
module lcd_timing_pattern_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 210,
  parameter int H_SYNC   = 1,
  parameter int H_BP     = 45,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 22,
  parameter int V_SYNC   = 1,
  parameter int V_BP     = 22,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CNT_W    = 12,
  parameter int CHK_LOG2 = 5
) (
  input logic                         pixel_clk_i,
  input logic                         rst_i,
  lcd_timing_pattern_gen_if.master    lcd_if
);

  localparam int H_TOTAL   = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL   = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int H_ACT_S   = H_SYNC + H_BP;
  localparam int H_ACT_E   = H_ACT_S + H_ACTIVE;
  localparam int V_ACT_S   = V_SYNC + V_BP;
  localparam int V_ACT_E   = V_ACT_S + V_ACTIVE;
  localparam int BAR_W     = H_ACTIVE / 8;
  localparam int GRAD_STEP = (H_ACTIVE / 64 < 1) ? 1 : H_ACTIVE / 64;

  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_W  = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_W  = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_S_W = CNT_W'(H_ACT_S);
  localparam logic [CNT_W-1:0] H_ACT_E_W = CNT_W'(H_ACT_E);
  localparam logic [CNT_W-1:0] V_ACT_S_W = CNT_W'(V_ACT_S);
  localparam logic [CNT_W-1:0] V_ACT_E_W = CNT_W'(V_ACT_E);
  // One pixel before the active area: the step counters are cleared here so that
  // they already describe PIX_X=0 on the first active pixel.
  localparam logic [CNT_W-1:0] H_PRE_W   = CNT_W'(H_ACT_S - 1);
  localparam logic [CNT_W-1:0] BAR_LAST  = CNT_W'(BAR_W - 1);
  localparam logic [CNT_W-1:0] GRAD_LAST = CNT_W'(GRAD_STEP - 1);

  localparam logic HS_ACT = (HS_POL != 0);
  localparam logic VS_ACT = (VS_POL != 0);

  // Counters and pattern state
  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  logic [1:0]       mode_q, mode_d;
  logic [15:0]      solid_q, solid_d;
  logic [2:0]       bar_idx_q, bar_idx_d;
  logic [CNT_W-1:0] bar_cnt_q, bar_cnt_d;
  logic [5:0]       grad_q, grad_d;
  logic [CNT_W-1:0] grad_cnt_q, grad_cnt_d;

  // Registered outputs
  logic             de_q, de_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic [15:0]      rgb_q, rgb_d;
  logic [CNT_W-1:0] pix_x_q, pix_x_d;
  logic [CNT_W-1:0] pix_y_q, pix_y_d;
  logic             fs_q, fs_d;

  // Decoded view of the current counter state
  logic             h_wrap;
  logic             frame_top;
  logic             h_act;
  logic             v_act;
  logic             de_c;
  logic [15:0]      bar_rgb;

  always_comb begin
    h_wrap    = (h_q == H_LAST);
    frame_top = (h_q == '0) && (v_q == '0);
    h_act     = (h_q >= H_ACT_S_W) && (h_q < H_ACT_E_W);
    v_act     = (v_q >= V_ACT_S_W) && (v_q < V_ACT_E_W);
    de_c      = h_act & v_act;
  end

  // h/v counters; v advances only on the h wrap
  always_comb begin
    h_d = h_wrap ? '0 : h_q + CNT_W'(1);
    v_d = v_q;
    if (h_wrap) begin
      v_d = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
    end
  end

  // Pattern selection is latched only at the top of the frame so a frame never tears
  always_comb begin
    mode_d  = frame_top ? lcd_if.mode  : mode_q;
    solid_d = frame_top ? lcd_if.solid : solid_q;
  end

  // Step counters replace PIX_X/BAR_W and PIX_X/GRAD_STEP divisions.
  // bar index and grey level saturate; the last bar absorbs the remainder.
  always_comb begin
    bar_idx_d  = bar_idx_q;
    bar_cnt_d  = bar_cnt_q;
    grad_d     = grad_q;
    grad_cnt_d = grad_cnt_q;
    if (h_q == H_PRE_W) begin
      bar_idx_d  = '0;
      bar_cnt_d  = '0;
      grad_d     = '0;
      grad_cnt_d = '0;
    end else if (h_act) begin
      if (bar_idx_q != 3'd7) begin
        if (bar_cnt_q == BAR_LAST) begin
          bar_cnt_d = '0;
          bar_idx_d = bar_idx_q + 3'd1;
        end else begin
          bar_cnt_d = bar_cnt_q + CNT_W'(1);
        end
      end
      if (grad_cnt_q == GRAD_LAST) begin
        grad_cnt_d = '0;
        if (grad_q != 6'd63) begin
          grad_d = grad_q + 6'd1;
        end
      end else begin
        grad_cnt_d = grad_cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    bar_rgb = 16'h0000;
    case (bar_idx_q)
      3'd0:    bar_rgb = 16'hFFFF;
      3'd1:    bar_rgb = 16'hFFE0;
      3'd2:    bar_rgb = 16'h07FF;
      3'd3:    bar_rgb = 16'h07E0;
      3'd4:    bar_rgb = 16'hF81F;
      3'd5:    bar_rgb = 16'hF800;
      3'd6:    bar_rgb = 16'h001F;
      default: bar_rgb = 16'h0000;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    de_d    = de_c;
    hs_d    = (h_q < H_SYNC_W) ? HS_ACT : ~HS_ACT;
    vs_d    = (v_q < V_SYNC_W) ? VS_ACT : ~VS_ACT;
    fs_d    = frame_top;
    pix_x_d = de_c ? (h_q - H_ACT_S_W) : '0;
    pix_y_d = de_c ? (v_q - V_ACT_S_W) : '0;
    rgb_d   = 16'h0000;
    if (de_c) begin
      case (mode_q)
        2'd0:    rgb_d = bar_rgb;
        2'd1:    rgb_d = {grad_q[5:1], grad_q, grad_q[5:1]};
        2'd2:    rgb_d = (pix_x_d[CHK_LOG2] ^ pix_y_d[CHK_LOG2]) ? 16'hFFFF : 16'h0000;
        default: rgb_d = solid_q;
      endcase
    end
  end

  always_ff @(posedge pixel_clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_q        <= '0;
      v_q        <= '0;
      mode_q     <= '0;
      solid_q    <= '0;
      bar_idx_q  <= '0;
      bar_cnt_q  <= '0;
      grad_q     <= '0;
      grad_cnt_q <= '0;
      de_q       <= 1'b0;
      hs_q       <= ~HS_ACT;
      vs_q       <= ~VS_ACT;
      rgb_q      <= '0;
      pix_x_q    <= '0;
      pix_y_q    <= '0;
      fs_q       <= 1'b0;
    end else begin
      h_q        <= h_d;
      v_q        <= v_d;
      mode_q     <= mode_d;
      solid_q    <= solid_d;
      bar_idx_q  <= bar_idx_d;
      bar_cnt_q  <= bar_cnt_d;
      grad_q     <= grad_d;
      grad_cnt_q <= grad_cnt_d;
      de_q       <= de_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      rgb_q      <= rgb_d;
      pix_x_q    <= pix_x_d;
      pix_y_q    <= pix_y_d;
      fs_q       <= fs_d;
    end
  end

  assign lcd_if.de          = de_q;
  assign lcd_if.hsync       = hs_q;
  assign lcd_if.vsync       = vs_q;
  assign lcd_if.r           = rgb_q[15:11];
  assign lcd_if.g           = rgb_q[10:5];
  assign lcd_if.b           = rgb_q[4:0];
  assign lcd_if.pix_x       = pix_x_q;
  assign lcd_if.pix_y       = pix_y_q;
  assign lcd_if.frame_start = fs_q;

endmodule

// File: tb/tb_lcd_timing_pattern_gen.sv
// tb/tb_lcd_timing_pattern_gen.sv - self-checking bench for lcd_timing_pattern_gen
module tb_lcd_timing_pattern_gen;
  localparam int HA  = 130;
  localparam int HFP = 3;
  localparam int HS  = 2;
  localparam int HB  = 3;
  localparam int VA  = 6;
  localparam int VFP = 2;
  localparam int VS  = 1;
  localparam int VB  = 2;
  localparam int HSP = 0;
  localparam int VSP = 1;
  localparam int CW  = 8;
  localparam int CL  = 2;
  localparam int HT  = HS + HB + HA + HFP;
  localparam int VT  = VS + VB + VA + VFP;
  localparam int FR  = HT * VT;
  localparam int OW  = 20 + 2 * CW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lcd_timing_pattern_gen_if #(.CNT_W(CW)) bus ();

  lcd_timing_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(HSP), .VS_POL(VSP), .CNT_W(CW), .CHK_LOG2(CL)
  ) dut (
    .pixel_clk_i(clk),
    .rst_i(rst),
    .lcd_if(bus)
  );

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  int k      = 0;
  int mode_f = 0;
  logic [15:0] solid_f = 16'h0;
  int de_cnt = 0;
  int hs_cnt = 0;
  int vs_cnt = 0;

  // Expected outputs for one pixel position, straight from the timing/pattern rules.
  function automatic logic [OW-1:0] model(int h, int v, int md, logic [15:0] sc);
    bit ha, va, de, hsy, vsy, fs;
    int x, y, bi, gi, st;
    logic [15:0] c;
    logic [5:0]  gg;
    ha  = (h >= HS + HB) && (h < HS + HB + HA);
    va  = (v >= VS + VB) && (v < VS + VB + VA);
    de  = ha && va;
    x   = de ? h - (HS + HB) : 0;
    y   = de ? v - (VS + VB) : 0;
    hsy = (h < HS) ? (HSP != 0) : (HSP == 0);
    vsy = (v < VS) ? (VSP != 0) : (VSP == 0);
    fs  = (h == 0) && (v == 0);
    c   = 16'h0;
    if (de) begin
      case (md)
        0: begin
          bi = x / (HA / 8);
          if (bi > 7) bi = 7;
          case (bi)
            0: c = 16'hFFFF; 1: c = 16'hFFE0; 2: c = 16'h07FF; 3: c = 16'h07E0;
            4: c = 16'hF81F; 5: c = 16'hF800; 6: c = 16'h001F; default: c = 16'h0000;
          endcase
        end
        1: begin
          st = (HA / 64 < 1) ? 1 : HA / 64;
          gi = x / st;
          if (gi > 63) gi = 63;
          gg = 6'(gi);
          c  = {gg[5:1], gg, gg[5:1]};
        end
        2: c = (x[CL] ^ y[CL]) ? 16'hFFFF : 16'h0000;
        default: c = sc;
      endcase
    end
    return {de, hsy, vsy, c, x[CW-1:0], y[CW-1:0], fs};
  endfunction

  function automatic logic [OW-1:0] reset_vec();
    return {1'b0, (HSP == 0), (VSP == 0), 16'h0, {CW{1'b0}}, {CW{1'b0}}, 1'b0};
  endfunction

  function automatic logic [OW-1:0] observed();
    return {bus.de, bus.hsync, bus.vsync, bus.r, bus.g, bus.b, bus.pix_x, bus.pix_y,
            bus.frame_start};
  endfunction

  task automatic check(string tag, logic [OW-1:0] obs, logic [OW-1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  // One clock: advance the model on the rising edge, compare on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      k++;
      if ((k - 1) % FR == 0) begin
        mode_f  = int'(bus.mode);
        solid_f = bus.solid;
      end
    end
    @(negedge clk);
    if (rst) begin
      check("reset_state", observed(), reset_vec());
    end else begin
      check("pixel", observed(), model((k - 1) % HT, ((k - 1) / HT) % VT, mode_f, solid_f));
      de_cnt += int'(bus.de);
      hs_cnt += int'(bus.hsync == (HSP != 0));
      vs_cnt += int'(bus.vsync == (VSP != 0));
      if (k % FR == 0) begin
        check("de_per_frame", OW'(de_cnt), OW'(HA * VA));
        check("hsync_per_frame", OW'(hs_cnt), OW'(HS * VT));
        check("vsync_per_frame", OW'(vs_cnt), OW'(VS * HT));
        de_cnt = 0;
        hs_cnt = 0;
        vs_cnt = 0;
      end
    end
  endtask

  initial begin
    int chg;
    bus.mode  = 2'd0;
    bus.solid = 16'h0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("frame_start_after_release", OW'(bus.frame_start), OW'(1));
    for (int f = 0; f < 10; f++) begin
      chg = int'($urandom_range(1, FR - 2));
      for (int i = 0; i < FR; i++) begin
        if (i == chg) begin
          bus.mode  = 2'(f % 4);
          bus.solid = (f == 2) ? 16'hF800 : 16'($urandom);
        end
        if (f == 6 && i == HT * 4 + 60) begin
          rst = 1'b1;
          k = 0;
          de_cnt = 0;
          hs_cnt = 0;
          vs_cnt = 0;
          #1;
          check("async_reset_mid_line", observed(), reset_vec());
          repeat (3) tick();
          rst = 1'b0;
        end
        tick();
      end
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
